// File: rtl/sys_time_generator.sv
// Free-running 64-bit system time, hard-aligned to SYNC0 on an armed edge and
// slewed back into alignment on every later edge.
module sys_time_generator #(
  parameter int unsigned SYNC_DELAY = 3,
  parameter int unsigned MAX_CORR   = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               SYNC_IN,
  input  logic               SET_REQ,
  input  logic [63:0]        SET_TIME,
  input  logic [31:0]        SYNC_PERIOD,
  output logic [63:0]        SYS_TIME,
  output logic               SET_DONE,
  output logic               LOCKED,
  output logic signed [15:0] ERR
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t             state_q, state_d;
  logic [63:0]        time_q, time_d;
  logic [63:0]        cap_q, cap_d;
  logic [63:0]        last_q, last_d;
  logic signed [31:0] pend_q, pend_d;
  logic               done_q, done_d;
  logic               locked_q, locked_d;
  logic signed [15:0] err_q, err_d;
  logic               sync1_q, sync2_q, sync3_q;

  logic               edge_s;
  logic [63:0]        incr;
  logic signed [31:0] pend_step;
  logic [63:0]        expected;
  logic signed [63:0] err_full;
  logic [63:0]        err_mag;

  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)       return 16'sd32767;
    else if (v < -64'sd32767) return -16'sd32767;
    return signed'(v[15:0]);
  endfunction

  assign edge_s = sync2_q & ~sync3_q;

  always_comb begin
    incr      = 64'd1;
    pend_step = pend_q;
    if (pend_q > 0) begin
      incr      = 64'd2;
      pend_step = pend_q - 32'sd1;
    end else if (pend_q < 0) begin
      incr      = 64'd0;
      pend_step = pend_q + 32'sd1;
    end

    // err is measured against the value the counter would show at E+1
    expected = last_q + {32'd0, SYNC_PERIOD};
    err_full = signed'(expected - (time_q + 64'd1));
    err_mag  = err_full[63] ? (~err_full + 64'd1) : err_full;

    state_d  = state_q;
    time_d   = time_q + incr;
    cap_d    = cap_q;
    last_d   = last_q;
    pend_d   = pend_step;
    done_d   = 1'b0;
    locked_d = locked_q;
    err_d    = err_q;

    if (edge_s) begin
      unique case (state_q)
        ARMED: begin
          time_d   = cap_q + 64'(SYNC_DELAY);
          last_d   = cap_q + 64'(SYNC_DELAY);
          pend_d   = '0;
          done_d   = 1'b1;
          locked_d = 1'b1;
          err_d    = '0;
          state_d  = RUN;
        end
        RUN: begin
          last_d = expected;
          err_d  = sat16(err_full);
          if (err_mag <= 64'(MAX_CORR)) begin
            time_d   = time_q + 64'd1;
            pend_d   = signed'(err_full[31:0]);
            locked_d = 1'b1;
          end else begin
            time_d   = expected;
            pend_d   = '0;
            locked_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A same-cycle edge has already been handled with the old capture above
    if (SET_REQ) begin
      cap_d   = SET_TIME;
      state_d = ARMED;
      pend_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      time_q   <= '0;
      cap_q    <= '0;
      last_q   <= '0;
      pend_q   <= '0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      cap_q    <= cap_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      sync1_q  <= SYNC_IN;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
    end
  end

  assign SYS_TIME = time_q;
  assign SET_DONE = done_q;
  assign LOCKED   = locked_q;
  assign ERR      = err_q;

endmodule

// File: doc/sys_time_generator.md
Name: sys_time_generator

Overview:
- Produces the free-running 64-bit system time (SYS_TIME) in clock ticks, the value the per-transducer time-count generators take modulo each cycle.
- Aligns SYS_TIME to an external sync pulse (EtherCAT SYNC0) by hard-loading a host-supplied time on an armed edge.
- Keeps it aligned afterwards by bounded slew corrections at every subsequent edge.

Parameters:
- SYNC_DELAY, 3, ticks added at hard load to compensate synchronizer and edge-detect latency.
- MAX_CORR, 16, largest |error| in ticks corrected by slewing; beyond this a hard reload occurs.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- SYNC_IN  in  1  asynchronous sync pulse; only the rising edge is used.
- SET_REQ  in  1  one-cycle strobe that arms a load of SET_TIME on the next sync edge.
- SET_TIME  in  64  tick value that corresponds to the next sync edge; captured on SET_REQ.
- SYNC_PERIOD  in  32  nominal ticks between sync edges; sampled at each edge.
- SYS_TIME  out  64  system time.
- SET_DONE  out  1  one-cycle pulse when an armed load completes.
- LOCKED  out  1  high while tracking within MAX_CORR.
- ERR  out  16  signed error from the last edge in RUN, saturated to ±32767.

Behaviour:
- Reset (asynchronous, RST_N low): SYS_TIME=0, SET_DONE=0, LOCKED=0, ERR=0, state IDLE, pending correction=0, captured time=0, last_target=0, synchronizer flops=0.
- Edge detect: 2-FF synchronizer on SYNC_IN plus one delay flop; edge flag is high for one cycle E, 3 cycles after the first sampled high.
- Counter step: SYS_TIME increments every cycle, 64-bit modulo 2^64.
  - The step is normally +1.
  - While a correction is pending, the step is +2 (positive error) or +0 (negative error), and |pending| decrements by 1 per cycle.
- States:
  - IDLE: free-run; edges ignored; SET_REQ -> ARMED, capture SET_TIME.
  - ARMED: free-run with step +1 (pending cleared on entry); SET_REQ recaptures SET_TIME. On edge at E:
    - SYS_TIME(E+1) = captured + SYNC_DELAY, and last_target takes the same value.
    - SET_DONE=1 for cycle E+1 only; LOCKED=1; ERR=0.
    - Next state RUN.
  - RUN: on edge at E:
    - expected = last_target + SYNC_PERIOD; err = expected - (SYS_TIME(E)+1), 64-bit signed; last_target <= expected.
    - err=0: no action.
    - 0<|err|<=MAX_CORR: SYS_TIME(E+1) = SYS_TIME(E)+1; pending = err, applied from E+1 onward; LOCKED=1.
    - |err|>MAX_CORR: SYS_TIME(E+1) = expected; pending = 0; LOCKED=0.
    - ERR updated in E+1 in all three cases.
    - SET_REQ in RUN -> ARMED, capture SET_TIME; LOCKED unchanged until the next load.
- A new edge while a correction is pending discards the old pending value; err is recomputed from the current SYS_TIME.
- SET_REQ and edge in the same cycle:
  - The edge is processed first, using the state and captured value held before that cycle.
  - SET_TIME is then captured and the state becomes ARMED.
- SET_DONE never pulses outside an ARMED load.
- Edges closer together than 3 cycles may merge; this is not required to be detected.

Test Plan:
- Reset then free-run 10 cycles -> SYS_TIME 1..10, LOCKED=0, SET_DONE=0; SYNC_IN pulses in IDLE change nothing.
- SET_REQ with SET_TIME=1000, then SYNC_IN rise -> SYS_TIME=1003 in E+1, SET_DONE high exactly one cycle, LOCKED=1.
- After that load, SYNC_PERIOD=2000 with the next edge flag exactly 2000 cycles later -> err=0, ERR=0, SYS_TIME at E+1 = 3003, step stays +1.
- Next edge 1998 cycles after the load edge (early by 2) -> SYS_TIME(E)=3000, err=+2, SYS_TIME 3001, 3003, 3005 at E+1..E+3, then +1 per cycle; ERR=2, LOCKED=1.
- Edge 20 cycles late with MAX_CORR=16 -> ERR=-20, LOCKED=0, SYS_TIME(E+1)=expected; the next on-time edge -> LOCKED=1, ERR=0.
- SET_TIME=0xFFFF_FFFF_FFFF_FFFD armed and loaded -> SYS_TIME(E+1)=0, wrap is clean.
- RST_N low while ARMED -> all outputs 0 immediately; a following edge does not load.
